poly_audio_engine: RTL and testbench

POLY_AUDIO_ENGINE -- requirements
Module: poly_audio_engine

---
 rtl/poly_audio_pkg.sv | 31 +++
 rtl/audio_voice.sv | 80 ++++++++
 rtl/poly_audio_engine.sv | 76 +++++++
 tb/tb_poly_audio_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/poly_audio_pkg.sv
// Shared constants, LFSR definition and per-voice state type for the poly audio engine.
// The noise variant of voice 0 is enabled by defining POLY_AUDIO_NOISE_EN.
package poly_audio_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_DIV_W      = 16;
  localparam int DEF_VOL_W      = 3;

  // Voice state is held at the widest supported sizes; instances zero-extend into it.
  localparam int VS_DIV_W = 32;
  localparam int VS_VOL_W = 8;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic [VS_DIV_W-1:0] period;
    logic [VS_VOL_W-1:0] vol;
    logic [VS_DIV_W-1:0] pend_period;
    logic [VS_VOL_W-1:0] pend_vol;
    logic                pending;
    logic [VS_DIV_W-1:0] counter;
    logic                square;
  } voice_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/audio_voice.sv
// One square-wave voice: half-period divider, glitch-free pending update, gated volume output.
// With POLY_AUDIO_NOISE_EN defined, the NOISE instance gates its volume by an LFSR instead.
module audio_voice
  import poly_audio_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int VOL_W = DEF_VOL_W
`ifdef POLY_AUDIO_NOISE_EN
  , parameter bit NOISE = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_period,
  input  logic [VOL_W-1:0] wr_vol,
  output logic [VOL_W-1:0] contrib
);

  voice_state_t st;
  voice_state_t st_next;
  logic         idle;
  logic         wrap;
  logic         apply;
  logic         gate;

  always_comb begin
    idle    = (st.period == '0);
    wrap    = !idle && (st.counter == st.period - VS_DIV_W'(1));
    apply   = st.pending && (idle || wrap);
    st_next = st;

    if (idle) begin
      st_next.counter = '0;
      st_next.square  = 1'b0;
    end else if (wrap) begin
      st_next.counter = '0;
      st_next.square  = ~st.square;
    end else begin
      st_next.counter = st.counter + VS_DIV_W'(1);
    end

    if (apply) begin
      st_next.period  = st.pend_period;
      st_next.vol     = st.pend_vol;
      st_next.pending = 1'b0;
      if (st.pend_period == '0) st_next.square = 1'b0;
    end

    // A write landing on the apply edge stays pending for the next wrap.
    if (wr_en) begin
      st_next.pend_period = VS_DIV_W'(wr_period);
      st_next.pend_vol    = VS_VOL_W'(wr_vol);
      st_next.pending     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= '0;
    else        st <= st_next;
  end

`ifdef POLY_AUDIO_NOISE_EN
  if (NOISE) begin : g_noise
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    lfsr <= LFSR_SEED;
      else if (wrap) lfsr <= lfsr_step(lfsr);
    end
    assign gate = !idle && lfsr[0];
  end else begin : g_square
    assign gate = st.square;
  end
`else
  assign gate = st.square;
`endif

  assign contrib = VOL_W'(gate ? st.vol : '0);

endmodule

// File: rtl/poly_audio_engine.sv
// Polyphonic square-wave engine: config handshake, NUM_VOICES voices, mixer and 1st-order PDM.
// Define POLY_AUDIO_NOISE_EN to turn voice 0 into an LFSR noise voice.
module poly_audio_engine
  import poly_audio_pkg::*;
#(
  parameter  int NUM_VOICES = DEF_NUM_VOICES,
  parameter  int DIV_W      = DEF_DIV_W,
  parameter  int VOL_W      = DEF_VOL_W,
  localparam int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int SUM_W      = VOL_W + $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [VOICE_W-1:0] cfg_voice,
  input  logic [DIV_W-1:0]   cfg_period,
  input  logic [VOL_W-1:0]   cfg_vol,
  output logic               audio,
  output logic [SUM_W-1:0]   mix_level
);

  logic             ready_q;
  logic             accept;
  logic [VOL_W-1:0] contrib [NUM_VOICES];
  logic [SUM_W-1:0] mix_sum;
  logic [SUM_W-1:0] acc;
  logic [SUM_W:0]   acc_sum;

  assign cfg_ready = ready_q;
  assign accept    = cfg_valid && ready_q;

  // Ready drops for the single commit cycle after each accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= !accept;
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    audio_voice #(
      .DIV_W(DIV_W),
      .VOL_W(VOL_W)
`ifdef POLY_AUDIO_NOISE_EN
      , .NOISE(i == 0)
`endif
    ) u_voice (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (accept && (cfg_voice == VOICE_W'(i))),
      .wr_period (cfg_period),
      .wr_vol    (cfg_vol),
      .contrib   (contrib[i])
    );
  end

  // SUM_W has room for NUM_VOICES full-scale volumes, so the sum cannot wrap.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) mix_sum = mix_sum + SUM_W'(contrib[i]);
  end

  assign acc_sum = {1'b0, acc} + {1'b0, mix_level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_level <= '0;
      acc       <= '0;
      audio     <= 1'b0;
    end else begin
      mix_level <= mix_sum;
      acc       <= acc_sum[SUM_W-1:0];
      audio     <= acc_sum[SUM_W];
    end
  end

endmodule

// File: tb/tb_poly_audio_engine.sv
// Self-checking bench for poly_audio_engine: directed scenarios plus random writes,
// compared every cycle against a time-arithmetic reference model.
module tb_poly_audio_engine;

  localparam int NV = 4;
  localparam int SW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_voice = '0;
  logic [15:0] cfg_period = '0;
  logic [2:0]  cfg_vol = '0;
  logic        audio;
  logic [SW-1:0] mix_level;

  // Second instance with three voices so an out-of-range index is encodable.
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [1:0]  b_voice = '0;
  logic [15:0] b_period = '0;
  logic [2:0]  b_vol = '0;
  logic        b_audio;
  logic [4:0]  b_mix;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_audio_engine dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice), .cfg_period(cfg_period), .cfg_vol(cfg_vol),
    .audio(audio), .mix_level(mix_level)
  );

  poly_audio_engine #(.NUM_VOICES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_voice(b_voice), .cfg_period(b_period), .cfg_vol(b_vol),
    .audio(b_audio), .mix_level(b_mix)
  );

  // Reference model: each voice is described by the edge its settings took effect
  // (st_t) and its square level right after that edge (base); levels follow by division.
  int m_t = 0;
  int act_p [NV];
  int act_v [NV];
  int st_t  [NV];
  int base  [NV];
  int pend  [NV];
  int pp    [NV];
  int pv    [NV];
  int m_acc, m_mix, m_audio, m_ready, m_csum;

  function automatic int sq_at(int i, int t);
    if (act_p[i] == 0) return 0;
    return base[i] ^ (((t - st_t[i]) / act_p[i]) & 1);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_mix = 0; m_audio = 0; m_ready = 0; m_csum = 0;
    for (int i = 0; i < NV; i++) begin
      act_p[i] = 0; act_v[i] = 0; st_t[i] = m_t; base[i] = 0;
      pend[i] = 0; pp[i] = 0; pv[i] = 0;
    end
  endtask

  task automatic model_edge();
    int wr, prev, wrap_now;
    wr = (cfg_valid && m_ready != 0) ? 1 : 0;
    m_audio = ((m_acc + m_mix) >= 32) ? 1 : 0;
    m_acc = (m_acc + m_mix) % 32;
    m_mix = m_csum;
    m_t++;
    for (int i = 0; i < NV; i++) begin
      prev = sq_at(i, m_t - 1);
      wrap_now = (act_p[i] != 0 && ((m_t - st_t[i]) % act_p[i]) == 0) ? 1 : 0;
      if (pend[i] != 0 && (act_p[i] == 0 || wrap_now != 0)) begin
        base[i]  = (pp[i] != 0 && wrap_now != 0) ? 1 - prev : 0;
        act_p[i] = pp[i];
        act_v[i] = pv[i];
        st_t[i]  = m_t;
        pend[i]  = 0;
      end
      if (wr != 0 && int'(cfg_voice) == i) begin
        pend[i] = 1; pp[i] = int'(cfg_period); pv[i] = int'(cfg_vol);
      end
    end
    m_ready = (wr != 0) ? 0 : 1;
    m_csum = 0;
    for (int i = 0; i < NV; i++) m_csum += sq_at(i, m_t) * act_v[i];
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m_t);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", int'(cfg_ready), m_ready);
    chk("mix", int'(mix_level), m_mix);
    chk("audio", int'(audio), m_audio);
  endtask

  task automatic write(int v, int p, int vol);
    if (m_ready == 0) tick();
    cfg_valid = 1'b1; cfg_voice = 2'(v); cfg_period = 16'(p); cfg_vol = 3'(vol);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_audio", int'(audio), 0);
    chk("rst_mix", int'(mix_level), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ones, nz, seen, prev_mix;
    #2;
    do_reset();

    // Idle after reset
    repeat (1000) tick();

    // Single tone: mix averages 3.5, so about 350 ones in 3200 cycles
    write(0, 4, 7);
    ones = 0;
    repeat (3200) begin
      tick();
      ones += int'(audio);
    end
    chk("density", (ones >= 318 && ones <= 382) ? 1 : 0, 1);

    // Pending overwrite on a running voice
    write(1, 6, 3);
    repeat (20) tick();
    write(1, 10, 3);
    tick();
    write(1, 3, 3);
    repeat (40) tick();
    write(0, 0, 0);
    write(1, 0, 0);
    repeat (20) tick();

    // Out-of-range voice index on the three-voice instance
    b_voice = 2'd3; b_period = 16'd1; b_vol = 3'd7; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("oor_ready_low", int'(b_ready), 0);
    tick();
    chk("oor_ready_back", int'(b_ready), 1);
    nz = 0;
    repeat (40) begin
      tick();
      if (b_mix != 0 || b_audio != 0) nz++;
    end
    chk("oor_quiet", nz, 0);
    b_voice = 2'd2; b_period = 16'd1; b_vol = 3'd5; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (b_mix == 5'd5) seen++;
    end
    chk("inrange_mix", (seen > 0) ? 1 : 0, 1);

    // Full-scale chord, all voices in phase
    do_reset();
    write(0, 1, 7);
    write(1, 1, 7);
    write(2, 1, 7);
    write(3, 1, 7);
    repeat (4) tick();
    prev_mix = int'(mix_level);
    repeat (20) begin
      tick();
      chk("chord_pair", int'(mix_level) + prev_mix, 28);
      chk("chord_level", (mix_level == 0 || mix_level == 28) ? 1 : 0, 1);
      prev_mix = int'(mix_level);
    end

    // Reset mid-tone: voices must stay muted afterwards
    do_reset();
    repeat (30) tick();

    // Random writes, valid asserted regardless of ready
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid  = 1'b1;
        cfg_voice  = 2'($urandom_range(0, 3));
        cfg_period = 16'($urandom_range(0, 9));
        cfg_vol    = 3'($urandom_range(0, 7));
      end
      tick();
      cfg_valid = 1'b0;
    end

    // Reset with a write just accepted and another one in flight
    write(2, 3, 6);
    cfg_valid = 1'b1; cfg_voice = 2'd1; cfg_period = 16'd2; cfg_vol = 3'd4;
    #2;
    do_reset();
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
